// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared core constants for the fetch stage:
//   NOP_INSTR        - instruction presented when no valid fetch is at the head
//   INSTR_BYTES      - byte stride between sequential instructions
//   DEFAULT_RESET_PC - default first fetch address after reset
// -----------------------------------------------------------------------------
package if_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_fifo
// Synchronous FIFO with first-word fall-through head, flush, count, full and
// empty. Used for the PC tracking queue and the instruction output buffer.
//   clk, rst   - clock, synchronous active-high reset
//   flush      - empty the queue this cycle (push/pop ignored)
//   push/data  - enqueue when not full, or when full and popping together
//   pop        - dequeue head when not empty
//   head_data  - current head entry (valid only when !empty)
//   count      - number of stored entries (0..DEPTH)
//   full/empty - occupancy flags
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module if_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_en_s;
  logic             pop_en_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr_r - rd_ptr_r;
  assign empty     = (count == PTR_ZERO);
  assign full      = (count == DEPTH_C);
  assign pop_en_s  = pop && !empty && !flush;
  assign push_en_s = push && !flush && (!full || pop_en_s);
  assign head_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset because the pointers qualify them
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction fetch stage. Owns the fetch PC, issues word-aligned requests on a
// valid/ready channel, tracks the PC of every accepted request, buffers the
// in-order responses with their PC and presents them fall-through to IF/ID.
//   clk, rst                    - clock, synchronous active-high reset
//   redirect_valid/redirect_pc  - load new fetch PC, flush buffered/in-flight
//   imem_req_valid/ready/addr   - request channel (addr is fetch PC)
//   imem_rsp_valid/data         - in-order response, no backpressure
//   out_valid/out_ready         - head entry valid / IF/ID capture enable
//   out_pc/out_pcn/out_instr    - head PC, PC+4, instruction (NOP when idle)
// -----------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pcn,
  output logic [DATA_WIDTH-1:0] out_instr
);

  localparam int                    CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] NOP_C    = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] PC_ZERO  = {DATA_WIDTH{1'b0}};
  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW:0]           DEPTH_C  = (CW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]   fetch_pc_r;
  logic [CW-1:0]           outstanding_r;
  logic [CW-1:0]           drop_r;

  logic [DATA_WIDTH-1:0]   fetch_pc_nxt_s;
  logic [CW-1:0]           outstanding_nxt_s;
  logic [CW-1:0]           drop_nxt_s;

  logic                    accept_s;
  logic                    rsp_fire_s;
  logic                    drop_active_s;
  logic                    keep_rsp_s;
  logic [CW:0]             in_flight_s;
  logic                    head_valid_s;
  logic                    out_pop_s;

  logic [DATA_WIDTH-1:0]   pcq_head_s;
  logic [CW-1:0]           pcq_count_s;
  logic                    pcq_full_s;
  logic                    pcq_empty_s;
  logic [2*DATA_WIDTH-1:0] out_head_s;
  logic [CW-1:0]           out_count_s;
  logic                    out_full_s;
  logic                    out_empty_s;
  logic                    unused_ok_s;

  // Issue depends only on registered occupancy plus rst/redirect, so there is
  // no path from out_ready or the response channel. Counting dropped requests
  // in outstanding keeps out_fifo from ever overflowing.
  assign in_flight_s    = {1'b0, outstanding_r} + {1'b0, out_count_s};
  assign imem_req_valid = !rst && !redirect_valid && (in_flight_s < DEPTH_C);
  assign imem_req_addr  = fetch_pc_r;

  assign accept_s      = imem_req_valid && imem_req_ready;
  assign rsp_fire_s    = imem_rsp_valid && (outstanding_r != CNT_ZERO);
  assign drop_active_s = (drop_r != CNT_ZERO);
  assign keep_rsp_s    = rsp_fire_s && !redirect_valid && !drop_active_s;

  assign head_valid_s  = !rst && !redirect_valid && !out_empty_s;
  assign out_pop_s     = head_valid_s && out_ready;

  assign unused_ok_s   = ^{pcq_count_s, pcq_full_s, pcq_empty_s, out_full_s,
                           redirect_pc[1:0]};

  // Next fetch PC: redirect target (word aligned) wins over sequential advance
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    if (redirect_valid) begin
      fetch_pc_nxt_s = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (accept_s) begin
      fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
  end

  // Outstanding count: accept and response in one cycle cancel out
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({accept_s, rsp_fire_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Drop count: a redirect marks everything still in flight as stale, minus
  // a response that lands (and is discarded) in the redirect cycle itself
  always_comb begin
    drop_nxt_s = drop_r;
    if (redirect_valid) begin
      if (rsp_fire_s) begin
        drop_nxt_s = outstanding_r - CNT_ONE;
      end else begin
        drop_nxt_s = outstanding_r;
      end
    end else if (rsp_fire_s && drop_active_s) begin
      drop_nxt_s = drop_r - CNT_ONE;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Architectural fetch state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_r        <= drop_nxt_s;
    end
  end

  // PC of every accepted request, popped by each response (stale ones too)
  if_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_fire_s),
    .head_data (pcq_head_s),
    .count     (pcq_count_s),
    .full      (pcq_full_s),
    .empty     (pcq_empty_s)
  );

  // {pc, instr} buffer feeding IF/ID
  if_fetch_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (keep_rsp_s),
    .push_data ({pcq_head_s, imem_rsp_data}),
    .pop       (out_pop_s),
    .head_data (out_head_s),
    .count     (out_count_s),
    .full      (out_full_s),
    .empty     (out_empty_s)
  );

  // Output presentation: head entry when valid, otherwise PC 0 and NOP
  always_comb begin
    out_valid = head_valid_s;
    if (head_valid_s) begin
      out_pc    = out_head_s[2*DATA_WIDTH-1:DATA_WIDTH];
      out_instr = out_head_s[DATA_WIDTH-1:0];
    end else begin
      out_pc    = PC_ZERO;
      out_instr = NOP_C;
    end
    out_pcn = out_pc + PC_STEP;
  end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A behavioural instruction memory returns ~addr
// as the instruction word with a programmable in-order latency. A second
// instance starts at 0xFFFF_FFF8 to exercise address wrap.
// -----------------------------------------------------------------------------
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_pcn;
  logic [31:0] out_instr;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_pcn;
  logic [31:0] w_out_instr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  if_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcn(out_pcn), .out_instr(out_instr)
  );

  if_fetch #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_pc(w_out_pc), .out_pcn(w_out_pcn), .out_instr(w_out_instr)
  );

  // ---------------- memory model for dut: in-order, fixed latency ----------
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  function automatic int next_due(input int c, input int l, input int ld);
    return (c + l > ld) ? (c + l) : (ld + 1);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due       <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(next_due(cyc, lat, last_due));
        last_due <= next_due(cyc, lat, last_due);
      end
      if (mq_due.size() > 0 && mq_due[0] == cyc + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~mq_addr[0];
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  // 1-cycle memory for the wrap instance (always ready)
  always @(posedge clk) begin
    if (rst) begin
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= 32'h0;
    end else begin
      w_rsp_valid <= w_req_valid;
      w_rsp_data  <= ~w_req_addr;
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Starts and ends at the drive point (#1 after a posedge).
  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Consume n outputs (out_ready held high) and compare with a sequential run.
  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    int got;
    int budget;
    pc = start;
    got = 0;
    budget = 40;
    out_ready = 1'b1;
    while (got < n && budget > 0) begin
      @(negedge clk);
      if (out_valid) begin
        check("stream_pc", out_pc, pc);
        check("stream_pcn", out_pcn, pc + 32'd4);
        check("stream_instr", out_instr, ~pc);
        pc = pc + 32'd4;
        got++;
      end
      budget--;
      @(posedge clk); #1;
    end
    if (got < n) begin
      checks++;
      $display("FAIL stream_timeout: got %0d outputs expected %0d from %h", got, n, start);
    end
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ordy;
    logic        erv;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic ord,
                              input logic erv, input logic [31:0] ea,
                              input logic eov, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.rdy = rd; v.ordy = ord; v.erv = erv;
    v.eaddr = ea; v.eov = eov; v.epc = ep;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic        prev_stall;

    // reset
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    // streaming, 1-cycle memory
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12));
    // reset mid-stream, then stall with out_ready low
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'd0));
    // release
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16));

    @(posedge clk); #1;
    lat = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst            = tbl[i].rst;
      imem_req_ready = tbl[i].rdy;
      out_ready      = tbl[i].ordy;
      @(negedge clk);
      check("req_valid", {31'h0, imem_req_valid}, {31'h0, tbl[i].erv});
      if (tbl[i].erv) check("req_addr", imem_req_addr, tbl[i].eaddr);
      check("out_valid", {31'h0, out_valid}, {31'h0, tbl[i].eov});
      check("out_pc", out_pc, tbl[i].epc);
      check("out_pcn", out_pcn, tbl[i].epc + 32'd4);
      check("out_instr", out_instr, tbl[i].eov ? ~tbl[i].epc : NOP_INSTR);
      @(posedge clk); #1;
    end

    // ---- redirect with two stale requests in flight, latency 3 ----
    lat = 3;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    do_reset(2);
    @(posedge clk); #1;                 // cycle 1: request 0 accepted
    @(posedge clk); #1;                 // cycle 2: request 4 accepted
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    check("redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("redir_out_valid", {31'h0, out_valid}, 32'h0);
    check("redir_out_instr", out_instr, NOP_INSTR);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req_valid_after", {31'h0, imem_req_valid}, 32'h1);
    check("redir_req_addr_aligned", imem_req_addr, 32'h0000_0100);
    @(posedge clk); #1;
    expect_stream(32'h0000_0100, 3);

    // ---- back-to-back redirects under traffic: last one wins ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    check("b2b_out_valid_1", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    check("b2b_out_valid_2", {31'h0, out_valid}, 32'h0);
    check("b2b_req_valid_2", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_stream(32'h0000_0300, 5);

    // ---- random ready/out_ready stream, then reset mid-stream ----
    lat = 2;
    do_reset(2);
    exp_pc = 32'h0;
    prev_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) check("hold_valid", {31'h0, out_valid}, 32'h1);
      if (out_valid) begin
        check("rand_pc", out_pc, exp_pc);
        check("rand_instr", out_instr, ~exp_pc);
        if (out_ready) exp_pc = exp_pc + 32'd4;
      end
      prev_stall = out_valid && !out_ready;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pcn", out_pcn, 32'h4);
    check("rst_out_instr", out_instr, NOP_INSTR);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("rst_req_addr", imem_req_addr, 32'h0);
    @(posedge clk); #1;
    expect_stream(32'h0, 4);

    // ---- wrap instance: RESET_PC = FFFF_FFF8 ----
    do_reset(2);
    @(negedge clk);
    check("wrap_req_valid", {31'h0, w_req_valid}, 32'h1);
    check("wrap_addr_0", w_req_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_addr_1", w_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_addr_2", w_req_addr, 32'h0000_0000);
    check("wrap_out_valid", {31'h0, w_out_valid}, 32'h1);
    check("wrap_out_pc_0", w_out_pc, 32'hFFFF_FFF8);
    check("wrap_out_pcn_0", w_out_pcn, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_out_pc_1", w_out_pc, 32'hFFFF_FFFC);
    check("wrap_out_pcn_1", w_out_pcn, 32'h0000_0000);
    check("wrap_out_instr_1", w_out_instr, 32'h0000_0003);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_out_pc_2", w_out_pc, 32'h0000_0000);
    check("wrap_out_pcn_2", w_out_pcn, 32'h0000_0004);
    check("wrap_out_instr_2", w_out_instr, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the 5-stage core. Owns the architectural fetch PC and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Returned words are buffered, paired with their PC and PC+4, and presented to the IF/ID pipeline register. Redirects from branches and jumps flush buffered and in-flight fetches.

## Interface
- DATA_WIDTH, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: output buffer entries; also the cap on outstanding requests. Must be a power of two, ≥2.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  load new fetch PC, flush everything
- redirect_pc  in  DATA_WIDTH  redirect target; bits [1:0] ignored and treated as 00
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  DATA_WIDTH  request address (word aligned)
- imem_rsp_valid  in  1  response valid; no backpressure, in request order
- imem_rsp_data  in  DATA_WIDTH  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  IF/ID register captures this cycle (its enable)
- out_pc  out  DATA_WIDTH  PC of head instruction
- out_pcn  out  DATA_WIDTH  out_pc + 4
- out_instr  out  DATA_WIDTH  head instruction; NOP 32'h0000_0013 when out_valid=0

## Operation
- State: fetch_pc; pc_queue of accepted-request PCs (FIFO_DEPTH deep); out_fifo of {pc, instr} (FIFO_DEPTH deep); outstanding count; drop count.
- Issue: imem_req_valid = !rst && !redirect_valid && (outstanding + out_fifo count < FIFO_DEPTH). imem_req_addr = fetch_pc.
- Accept (valid && ready): push fetch_pc to pc_queue; fetch_pc += 4 modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0); outstanding +1.
- Response: pop pc_queue; outstanding −1. If drop count > 0, discard and decrement drop count; otherwise push {popped pc, data} into out_fifo.
- Response with outstanding == 0: ignored.
- Output: first-word fall-through from out_fifo head; out_pcn = out_pc + 4 with the same wrap. Pop when out_valid && out_ready.
- Redirect cycle: fetch_pc ← {redirect_pc[31:2], 2'b00}; out_fifo flushed; out_valid forced 0 and out_instr = NOP that cycle; no request issued; any response in that cycle is discarded; drop count ← outstanding minus that response. pc_queue entries for dropped requests drain normally.
- Back-to-back redirects: the last redirect wins; drop count accumulates correctly across both.
- Accept and response in the same cycle: outstanding is unchanged, and both queue operations apply.

## Timing
- Reset values: fetch_pc = RESET_PC; queues empty; outstanding = 0; drop count = 0; imem_req_valid = 0; out_valid = 0; out_pc = 0; out_pcn = 4; out_instr = NOP.
- First request is valid in the first cycle after rst deasserts.
- Request accepted in cycle N; earliest response in N+1; instruction visible on out_* in N+2, registered through out_fifo.
- With 1-cycle memory, ready always high and out_ready high, sustained throughput is 1 instruction/cycle.
- out_valid and out_* remain stable while out_ready = 0.
- No combinational path from out_ready or imem_rsp_* to imem_req_valid.
- rst mid-operation returns all state to reset values. Instruction memory shares rst, so no stale responses follow.

## Structure
- Shared core package holds: NOP_INSTR = 32'h0000_0013, INSTR_BYTES = 4, and the default RESET_PC.
- One sub-module: if_fetch_fifo. It is a synchronous FIFO with parameterised width and depth, flush, count, full/empty, and fall-through output. It is instantiated twice: pc_queue (DATA_WIDTH wide) and out_fifo (2×DATA_WIDTH wide).

## Test plan
- Reset, then 1-cycle memory and out_ready = 1 → requests to addresses 0, 4, 8, …; out_pc = 0, 4, 8 on consecutive cycles from cycle 2; out_pcn = out_pc + 4.
- Hold out_ready = 0 → exactly 4 requests issued, then imem_req_valid = 0; out_* hold PC 0. Release → 0, 4, 8, 12 drain in order and fetching resumes.
- Memory latency 3, 2 requests outstanding, redirect to 0x100 → both stale responses dropped; next out_valid shows out_pc = 0x100 with the correct instruction.
- Redirect to 0x103 → imem_req_addr = 0x100.
- Start at RESET_PC = 0xFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pcn for FFFF_FFFC = 0.
- Toggle imem_req_ready randomly, then assert rst mid-stream → outputs return to reset values the next cycle and fetch restarts at RESET_PC.
